mel_log_compress: RTL

MEL_LOG_COMPRESS -- requirements
Module: mel_log_compress

---
 rtl/mel_log_compress.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mel_log_compress.sv
// mel_log_compress: streaming log2 compressor for mel filterbank energies.
// Three-stage pipeline (leading-one detect, mantissa normalise, correct and
// register) producing an unsigned Q5.FRAC_BITS log2 per sample, tagged with
// its filter index inside the frame.
// Optional feature macro: LOG_CORR_EN adds a 16-entry piecewise correction
// of the Mitchell fraction; without it frac is the raw mantissa.
module mel_log_compress #(
    parameter int NUM_MEL_FILTERS = 40,
    parameter int IN_WIDTH        = 32,
    parameter int FRAC_BITS       = 11,
    parameter int OUT_WIDTH       = 5 + FRAC_BITS
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [IN_WIDTH-1:0]                mel_fbank_out,
    input  logic                               mel_fbank_valid,
    input  logic                               frame_start,
    output logic [OUT_WIDTH-1:0]               log_out,
    output logic                               log_valid,
    output logic [$clog2(NUM_MEL_FILTERS)-1:0] mel_idx,
    output logic                               frame_done
);

    localparam int IDX_W = $clog2(NUM_MEL_FILTERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MEL_FILTERS - 1);

    // Position of the most significant set bit; 0 when no bit is set.
    function automatic logic [4:0] lead_one(input logic [IN_WIDTH-1:0] x);
        logic [4:0] k;
        k = 5'd0;
        for (int b = 0; b < IN_WIDTH; b++) begin
            k = x[b] ? 5'(b) : k;
        end
        return k;
    endfunction

`ifdef LOG_CORR_EN
    // Correction table in units of 2^-11: round(2048*(log2(1+m)-m)) at the
    // midpoint m of each of the 16 mantissa segments.
    function automatic logic [7:0] corr_lut(input logic [3:0] seg);
        logic [7:0] c;
        case (seg)
            4'd0:    c = 8'd27;
            4'd1:    c = 8'd73;
            4'd2:    c = 8'd109;
            4'd3:    c = 8'd137;
            4'd4:    c = 8'd156;
            4'd5:    c = 8'd169;
            4'd6:    c = 8'd175;
            4'd7:    c = 8'd176;
            4'd8:    c = 8'd171;
            4'd9:    c = 8'd161;
            4'd10:   c = 8'd147;
            4'd11:   c = 8'd128;
            4'd12:   c = 8'd106;
            4'd13:   c = 8'd80;
            4'd14:   c = 8'd50;
            4'd15:   c = 8'd17;
            default: c = 8'd0;
        endcase
        return c;
    endfunction

    // Rescale the 2^-11 table to the configured fraction width.
    localparam int CORR_UP = (FRAC_BITS > 11) ? (FRAC_BITS - 11) : 0;
    localparam int CORR_DN = (FRAC_BITS < 11) ? (11 - FRAC_BITS) : 0;
    localparam logic [31:0] CORR_HALF = (32'd1 << CORR_DN) >> 1;
    localparam logic [32:0] FRAC_MAX  = (33'd1 << FRAC_BITS) - 33'd1;

    logic [31:0] corr_s;
    logic [32:0] sum_s;
`endif

    logic [IDX_W-1:0]     idx_cnt_r;
    logic [IDX_W-1:0]     tag_idx_s;
    logic [IDX_W-1:0]     next_cnt_s;

    logic                 s1_vld_r;
    logic [IN_WIDTH-1:0]  s1_x_r;
    logic [4:0]           s1_k_r;
    logic                 s1_zero_r;
    logic [IDX_W-1:0]     s1_idx_r;

    logic [4:0]           shamt_s;
    logic [FRAC_BITS-1:0] f_s;

    logic                 s2_vld_r;
    logic [4:0]           s2_k_r;
    logic [FRAC_BITS-1:0] s2_f_r;
    logic                 s2_zero_r;
    logic [IDX_W-1:0]     s2_idx_r;

    logic [FRAC_BITS-1:0] frac_s;

    // Index tag for the incoming sample and the counter value that follows it.
    always_comb begin
        tag_idx_s  = idx_cnt_r;
        next_cnt_s = idx_cnt_r;
        if (mel_fbank_valid && frame_start) begin
            tag_idx_s = {IDX_W{1'b0}};
        end else begin
            tag_idx_s = idx_cnt_r;
        end
        if (tag_idx_s == LAST_IDX) begin
            next_cnt_s = {IDX_W{1'b0}};
        end else begin
            next_cnt_s = tag_idx_s + IDX_W'(1);
        end
    end

    // Filter index counter, advancing only on accepted samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_cnt_r <= {IDX_W{1'b0}};
        end else if (mel_fbank_valid) begin
            idx_cnt_r <= next_cnt_s;
        end else begin
            idx_cnt_r <= idx_cnt_r;
        end
    end

    // Stage 1: capture sample, its index and its leading-one position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_r  <= 1'b0;
            s1_x_r    <= {IN_WIDTH{1'b0}};
            s1_k_r    <= 5'd0;
            s1_zero_r <= 1'b0;
            s1_idx_r  <= {IDX_W{1'b0}};
        end else begin
            s1_vld_r  <= mel_fbank_valid;
            s1_x_r    <= mel_fbank_out;
            s1_k_r    <= lead_one(mel_fbank_out);
            s1_zero_r <= (mel_fbank_out == {IN_WIDTH{1'b0}});
            s1_idx_r  <= tag_idx_s;
        end
    end

    // Normalise: shift the leading one to the top, keep the bits just below it.
    always_comb begin
        shamt_s = 5'(IN_WIDTH - 1) - s1_k_r;
        f_s     = FRAC_BITS'((s1_x_r << shamt_s) >> (IN_WIDTH - 1 - FRAC_BITS));
    end

    // Stage 2: register exponent and normalised fraction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_r  <= 1'b0;
            s2_k_r    <= 5'd0;
            s2_f_r    <= {FRAC_BITS{1'b0}};
            s2_zero_r <= 1'b0;
            s2_idx_r  <= {IDX_W{1'b0}};
        end else begin
            s2_vld_r  <= s1_vld_r;
            s2_k_r    <= s1_k_r;
            s2_f_r    <= f_s;
            s2_zero_r <= s1_zero_r;
            s2_idx_r  <= s1_idx_r;
        end
    end

`ifdef LOG_CORR_EN
    // Add the segment correction and saturate the fraction at all-ones.
    always_comb begin
        corr_s = ((32'(corr_lut(s2_f_r[FRAC_BITS-1 -: 4])) << CORR_UP) + CORR_HALF) >> CORR_DN;
        sum_s  = 33'(s2_f_r) + {1'b0, corr_s};
        if (sum_s > FRAC_MAX) begin
            frac_s = FRAC_MAX[FRAC_BITS-1:0];
        end else begin
            frac_s = sum_s[FRAC_BITS-1:0];
        end
    end
`else
    // Mitchell approximation: the mantissa bits are the fraction.
    always_comb begin
        frac_s = s2_f_r;
    end
`endif

    // Stage 3: registered outputs, forced to zero when no sample is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            log_valid  <= 1'b0;
            log_out    <= {OUT_WIDTH{1'b0}};
            mel_idx    <= {IDX_W{1'b0}};
            frame_done <= 1'b0;
        end else if (s2_vld_r) begin
            log_valid  <= 1'b1;
            log_out    <= s2_zero_r ? {OUT_WIDTH{1'b0}} : OUT_WIDTH'({s2_k_r, frac_s});
            mel_idx    <= s2_idx_r;
            frame_done <= (s2_idx_r == LAST_IDX);
        end else begin
            log_valid  <= 1'b0;
            log_out    <= {OUT_WIDTH{1'b0}};
            mel_idx    <= {IDX_W{1'b0}};
            frame_done <= 1'b0;
        end
    end

endmodule
